// File: rtl/fft_bfly_sched.sv
// Purpose: address/strobe sequencer for an in-place radix-2 DIF FFT over a shared sample RAM.
// Latency: first butterfly is issued 1 cycle after start is sampled; write strobes trail issues by MUL_LAT.
// Backpressure: i_hold freezes issue in RUN only; the write-back pipe always advances.
//
// Ports:
//   i_clk, i_rst (async, active-low), i_start, i_hold
//   o_busy, o_done, o_bf_valid, o_rd_addr_a/b, o_tw_idx
//   o_wr_en, o_wr_addr_a/b  (write-back for the butterfly issued MUL_LAT cycles earlier)
module fft_bfly_sched #(
    parameter int N       = 16,
    parameter int LOG2N   = 4,
    parameter int MUL_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_hold,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_bf_valid,
    output logic [LOG2N-1:0] o_rd_addr_a,
    output logic [LOG2N-1:0] o_rd_addr_b,
    output logic [LOG2N-2:0] o_tw_idx,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr_a,
    output logic [LOG2N-1:0] o_wr_addr_b
);
    localparam int KW = LOG2N - 1;
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;

    localparam logic [KW-1:0] K_LAST  = KW'(N / 2 - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(LOG2N - 1);
    localparam logic [DW-1:0] D_LAST  = DW'(MUL_LAT - 1);

    logic [2:0]       r_state;
    logic [SW-1:0]    r_stage;
    logic [KW-1:0]    r_k;
    logic [DW-1:0]    r_dcnt;

    logic [SW-1:0]    w_p;
    logic [LOG2N-1:0] w_span;
    logic [KW-1:0]    w_mask;
    logic [KW-1:0]    w_j;
    logic [KW-1:0]    w_hi;
    logic [KW-1:0]    w_tw;
    logic [LOG2N-1:0] w_a;
    logic [LOG2N-1:0] w_b;

    // span = 2^p with p = LOG2N-1-stage. The low p bits of k are j, the rest is
    // grp*span; doubling that part and re-inserting j gives grp*2*span + j.
    // This is a zero-bit insertion at position p, so no multiply or divide.
    always_comb begin
        w_p    = ST_LAST - r_stage;
        w_span = LOG2N'(1) << w_p;
        w_mask = w_span[KW-1:0] - KW'(1);
        w_j    = r_k & w_mask;
        w_hi   = r_k & ~w_mask;
        w_a    = {w_hi, 1'b0} | {1'b0, w_j};
        w_b    = w_a | w_span;
        // j < N>>(s+1), so j<<s < N/2 always fits the twiddle index width
        w_tw   = w_j << r_stage;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_stage     <= '0;
            r_k         <= '0;
            r_dcnt      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_bf_valid  <= 1'b0;
            o_rd_addr_a <= '0;
            o_rd_addr_b <= '0;
            o_tw_idx    <= '0;
        end else begin
            o_bf_valid <= 1'b0;
            o_done     <= (r_state == S_DONE);
            o_busy     <= (r_state == S_RUN) || (r_state == S_DRAIN);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_stage <= '0;
                        r_k     <= '0;
                    end
                end
                S_RUN: begin
                    // On hold the address outputs keep their last issued value.
                    if (!i_hold) begin
                        o_bf_valid  <= 1'b1;
                        o_rd_addr_a <= w_a;
                        o_rd_addr_b <= w_b;
                        o_tw_idx    <= w_tw;
                        if (r_k == K_LAST) begin
                            r_state <= S_DRAIN;
                            r_k     <= '0;
                            r_dcnt  <= '0;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Wait out the multiplier so the last write of this stage lands
                    // before the next stage's first read of that location.
                    if (r_dcnt == D_LAST) begin
                        if (r_stage == ST_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                            r_stage <= r_stage + SW'(1);
                            r_k     <= '0;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + DW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write-back delay line: advances every cycle regardless of state or hold,
    // so every issued butterfly retires exactly MUL_LAT cycles later.
    logic [MUL_LAT-1:0] r_wv;
    logic [LOG2N-1:0]   r_wa [MUL_LAT];
    logic [LOG2N-1:0]   r_wb [MUL_LAT];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wv <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_wa[i] <= '0;
                r_wb[i] <= '0;
            end
        end else begin
            r_wv[0] <= o_bf_valid;
            r_wa[0] <= o_rd_addr_a;
            r_wb[0] <= o_rd_addr_b;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_wv[i] <= r_wv[i-1];
                r_wa[i] <= r_wa[i-1];
                r_wb[i] <= r_wb[i-1];
            end
        end
    end

    assign o_wr_en     = r_wv[MUL_LAT-1];
    assign o_wr_addr_a = r_wa[MUL_LAT-1];
    assign o_wr_addr_b = r_wb[MUL_LAT-1];

endmodule
